// File: rtl/rx_pkt_if.sv
// Byte-stream and SRAM-write handshake bundle for the receive packet writer.
// The writer is the master of the SRAM write port; the radio/controller side is the slave.
interface rx_pkt_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        rx_abort;
   logic        master_write;
   logic [15:0] master_data_to_sram;
   logic        master_hint;
   logic        Pkt_Start_flag;
   logic        Crc_Error_Rollback;
   logic        pkt_done;
   logic        crc_err;
   logic        len_err;
   logic        busy;

   modport master (
      input  byte_in, byte_valid, rx_abort, master_hint,
      output byte_ready, master_write, master_data_to_sram,
             Pkt_Start_flag, Crc_Error_Rollback, pkt_done, crc_err, len_err, busy
   );

   modport slave (
      output byte_in, byte_valid, rx_abort, master_hint,
      input  byte_ready, master_write, master_data_to_sram,
             Pkt_Start_flag, Crc_Error_Rollback, pkt_done, crc_err, len_err, busy
   );
endinterface

// File: rtl/rx_pkt_writer.sv
// Receive packet writer: validates LEN, packs payload into 16-bit SRAM words,
// checks the trailing CRC-16/CCITT-FALSE and requests rollback on error or abort.
module rx_pkt_writer #(
   parameter int unsigned MAX_LEN  = 255,
   parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
   input  logic     clk,
   input  logic     rst_n,
   rx_pkt_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, START, PAYLOAD, CRC_HI, CRC_LO, FLUSH, CHECK, ROLLBACK
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  rem_q, rem_d;
   logic [15:0] crc_q, crc_d;
   logic [15:0] crc_rx_q, crc_rx_d;
   logic [7:0]  half_q, half_d;
   logic        half_vld_q, half_vld_d;
   logic        wr_q, wr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        abort_q, abort_d;
   logic        rdy_en_q;

   logic rdy;
   logic acc;
   logic len_bad;
   logic abort_in;

   function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   assign len_bad  = (bus.byte_in == 8'd0) || ({24'd0, bus.byte_in} > MAX_LEN);
   assign abort_in = bus.rx_abort && !abort_q &&
                     (state_q inside {START, PAYLOAD, CRC_HI, CRC_LO, FLUSH});

   // A second payload byte may only land once the single word buffer is free.
   always_comb begin
      rdy = 1'b0;
      case (state_q)
         IDLE:           rdy = 1'b1;
         PAYLOAD:        rdy = !half_vld_q || !wr_q;
         CRC_HI, CRC_LO: rdy = 1'b1;
         default:        rdy = 1'b0;
      endcase
      if (!rdy_en_q || abort_q || (bus.rx_abort && state_q != IDLE)) rdy = 1'b0;
   end

   assign acc = bus.byte_valid && rdy;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      crc_d      = crc_q;
      crc_rx_d   = crc_rx_q;
      half_d     = half_q;
      half_vld_d = half_vld_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      abort_d    = abort_q;

      if (wr_q && bus.master_hint) wr_d = 1'b0;

      if (abort_in) begin
         // The in-flight write is left to complete; FLUSH waits for it.
         abort_d    = 1'b1;
         half_vld_d = 1'b0;
         state_d    = FLUSH;
      end else begin
         case (state_q)
            IDLE: begin
               if (acc && !len_bad) begin
                  rem_d      = bus.byte_in;
                  crc_d      = CRC_INIT;
                  half_vld_d = 1'b0;
                  abort_d    = 1'b0;
                  state_d    = START;
               end
            end
            START: begin
               wr_d    = 1'b1;
               wdata_d = {8'h00, rem_q};
               state_d = PAYLOAD;
            end
            PAYLOAD: begin
               if (acc) begin
                  crc_d = crc16_upd(crc_q, bus.byte_in);
                  rem_d = rem_q - 8'd1;
                  if (half_vld_q) begin
                     wr_d       = 1'b1;
                     wdata_d    = {half_q, bus.byte_in};
                     half_vld_d = 1'b0;
                  end else begin
                     half_d     = bus.byte_in;
                     half_vld_d = 1'b1;
                  end
                  if (rem_q == 8'd1) state_d = CRC_HI;
               end
            end
            CRC_HI: begin
               if (acc) begin
                  crc_rx_d[15:8] = bus.byte_in;
                  state_d        = CRC_LO;
               end
            end
            CRC_LO: begin
               if (acc) begin
                  crc_rx_d[7:0] = bus.byte_in;
                  state_d       = FLUSH;
               end
            end
            FLUSH: begin
               if (abort_q) begin
                  if (!wr_q) state_d = ROLLBACK;
               end else if (half_vld_q) begin
                  if (!wr_q) begin
                     wr_d       = 1'b1;
                     wdata_d    = {half_q, 8'h00};
                     half_vld_d = 1'b0;
                  end
               end else if (!wr_q) begin
                  state_d = CHECK;
               end
            end
            CHECK: begin
               state_d = (crc_q == crc_rx_q) ? IDLE : ROLLBACK;
            end
            ROLLBACK: begin
               abort_d = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rem_q      <= 8'd0;
         crc_q      <= 16'h0000;
         crc_rx_q   <= 16'h0000;
         half_q     <= 8'd0;
         half_vld_q <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= 16'h0000;
         abort_q    <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         crc_q      <= crc_d;
         crc_rx_q   <= crc_rx_d;
         half_q     <= half_d;
         half_vld_q <= half_vld_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         abort_q    <= abort_d;
         rdy_en_q   <= 1'b1;
      end
   end

   assign bus.byte_ready          = rdy;
   assign bus.master_write        = wr_q;
   assign bus.master_data_to_sram = wdata_q;
   assign bus.Pkt_Start_flag      = (state_q == START);
   assign bus.Crc_Error_Rollback  = (state_q == ROLLBACK);
   assign bus.crc_err             = (state_q == ROLLBACK);
   assign bus.pkt_done            = (state_q == CHECK) && (crc_q == crc_rx_q);
   assign bus.len_err             = (state_q == IDLE) && acc && len_bad;
   assign bus.busy                = (state_q != IDLE);

endmodule
